// File: rtl/evt_count_arbiter.sv
// evt_count_arbiter: round-robin arbiter sequencing a shared event-counting engine
//   clk, rst     clock and asynchronous active-high reset
//   req          per-requester job request (level, held for the whole job)
//   x_in         per-requester event input; only the granted bit is counted
//   gnt          registered one-hot grant
//   busy         FSM not in IDLE
//   step         event count of the active job
//   done, abort  one-cycle completion / abort pulses
//   done_id      channel of the finished or aborted job, valid with done|abort
module evt_count_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TERM    = 3,
  parameter int TIMEOUT = 15,
  localparam int IW = $clog2(N_REQ),
  localparam int SW = $clog2(TERM + 1),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] x_in,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic [SW-1:0]    step,
  output logic             done,
  output logic             abort,
  output logic [IW-1:0]    done_id
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]       state, state_n;
  logic [IW-1:0]    id, id_n, ptr, ptr_n, win, did_n;
  logic [TW-1:0]    timer, timer_n, t_inc;
  logic [SW-1:0]    step_n, s_inc;
  logic [N_REQ-1:0] gnt_n;
  logic             done_n, abort_n;
  // Descending scan so the nearest set bit after the pointer is assigned last.
  always_comb begin
    win = ptr;
    for (int i = N_REQ; i >= 1; i--)
      if (req[(int'(ptr) + i) % N_REQ]) win = IW'((int'(ptr) + i) % N_REQ);
  end
  assign t_inc = (timer == '1) ? timer : timer + 1'b1;
  assign s_inc = (step == SW'(TERM)) ? step : step + 1'b1;
  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    step_n  = step;
    timer_n = timer;
    id_n    = id;
    ptr_n   = ptr;
    did_n   = done_id;
    done_n  = 1'b0;
    abort_n = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_n = RUN;
        gnt_n   = N_REQ'(1) << win;
        id_n    = win;
        ptr_n   = win;
        step_n  = '0;
        timer_n = '0;
      end
      RUN: begin
        if (!req[id] || (!x_in[id] && t_inc >= TW'(TIMEOUT))) begin
          state_n = IDLE;
          abort_n = 1'b1;
          did_n   = id;
          gnt_n   = '0;
          step_n  = '0;
          timer_n = '0;
        end else if (x_in[id]) begin
          step_n  = s_inc;
          timer_n = '0;
          if (s_inc == SW'(TERM)) begin
            state_n = DONE;
            done_n  = 1'b1;
            did_n   = id;
          end
        end else
          timer_n = t_inc;
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        step_n  = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      busy    <= 1'b0;
      step    <= '0;
      done    <= 1'b0;
      abort   <= 1'b0;
      done_id <= '0;
      id      <= '0;
      ptr     <= IW'(N_REQ - 1);
      timer   <= '0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      busy    <= state_n != IDLE;
      step    <= step_n;
      done    <= done_n;
      abort   <= abort_n;
      done_id <= did_n;
      id      <= id_n;
      ptr     <= ptr_n;
      timer   <= timer_n;
    end
endmodule

// File: tb/tb_evt_count_arbiter.sv
// tb_evt_count_arbiter: directed bench for evt_count_arbiter with hand-computed expectations
module tb_evt_count_arbiter;
  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] req = '0, x_in = '0, gnt;
  logic       busy, done, abort;
  logic [1:0] step, done_id;
  int nvec = 0, nerr = 0;

  evt_count_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .x_in(x_in), .gnt(gnt), .busy(busy),
    .step(step), .done(done), .abort(abort), .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic b,
                         input logic [1:0] s, input logic d, input logic a);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".step"}, 32'(step), 32'(s));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".abort"}, 32'(abort), 32'(a));
  endtask

  initial begin
    tick(); tick();
    chk_all("reset", 4'b0000, 0, 0, 0, 0);
    chk("reset.done_id", 32'(done_id), 0);
    rst = 1'b0;
    // single job on channel 0
    req = 4'b0001; x_in = 4'b0001;
    tick(); chk_all("single.grant", 4'b0001, 1, 0, 0, 0);
    tick(); chk("single.step1", 32'(step), 1);
    tick(); chk("single.step2", 32'(step), 2);
    tick(); chk_all("single.done", 4'b0001, 1, 3, 1, 0);
    chk("single.done_id", 32'(done_id), 0);
    req = 4'b0000;
    tick(); chk_all("single.idle", 4'b0000, 0, 0, 0, 0);
    // round robin from a fresh pointer
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b1111; x_in = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick(); chk("rr.grant", 32'(gnt), 32'(4'b0001 << (j % 4)));
      tick(); tick();
      tick(); chk("rr.done", 32'(done), 1);
      chk("rr.done_id", 32'(done_id), 32'(j % 4));
      chk("rr.abort", 32'(abort), 0);
      if (j == 4) req = 4'b0000;
      tick(); chk("rr.release", 32'(gnt), 0);
    end
    // timeout on channel 1 (pointer now 0)
    req = 4'b0010; x_in = 4'b0000;
    tick(); chk_all("to.grant", 4'b0010, 1, 0, 0, 0);
    for (int k = 0; k < 14; k++) begin
      tick(); chk_all("to.wait", 4'b0010, 1, 0, 0, 0);
    end
    tick(); chk_all("to.abort", 4'b0000, 0, 0, 0, 1);
    chk("to.done_id", 32'(done_id), 1);
    req = 4'b0000;
    tick(); chk_all("to.after", 4'b0000, 0, 0, 0, 0);
    // request drop on channel 2 with channel 0 pending
    req = 4'b0100;
    tick(); chk("drop.grant", 32'(gnt), 32'(4'b0100));
    x_in = 4'b0100;
    tick(); tick(); chk("drop.step2", 32'(step), 2);
    x_in = 4'b0000; req = 4'b0001;
    tick(); chk_all("drop.abort", 4'b0000, 0, 0, 0, 1);
    chk("drop.done_id", 32'(done_id), 2);
    tick(); chk("drop.next_grant", 32'(gnt), 32'(4'b0001));
    // final event coincides with request drop
    x_in = 4'b0001;
    tick(); tick(); chk("sim.step2", 32'(step), 2);
    req = 4'b0000;
    tick(); chk_all("sim.abort", 4'b0000, 0, 0, 0, 1);
    chk("sim.done_id", 32'(done_id), 0);
    x_in = 4'b0000;
    tick();
    // asynchronous reset mid-run
    req = 4'b0001; x_in = 4'b0001;
    tick(); tick(); tick(); chk("ar.step2", 32'(step), 2);
    #2 rst = 1'b1;
    #1 chk_all("ar.cleared", 4'b0000, 0, 0, 0, 0);
    req = 4'b0101; x_in = 4'b0000;
    tick(); rst = 1'b0;
    tick(); chk("ar.first_grant", 32'(gnt), 32'(4'b0001));
    req = 4'b0100;
    tick(); chk("ar.abort", 32'(abort), 1);
    req = 4'b0000;
    tick();
    // isolation: only the granted event bit counts
    req = 4'b0010;
    tick(); chk("iso.grant", 32'(gnt), 32'(4'b0010));
    for (int k = 0; k < 14; k++) begin
      x_in = (k % 2 == 0) ? 4'b1001 : 4'b0000;
      tick(); chk_all("iso.wait", 4'b0010, 1, 0, 0, 0);
    end
    x_in = 4'b1001;
    tick(); chk_all("iso.abort", 4'b0000, 0, 0, 0, 1);
    chk("iso.done_id", 32'(done_id), 1);
    req = 4'b0000; x_in = 4'b0000;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
